// File: rtl/seg_display_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_pkg
// Shared constants for the seven-segment display peripheral: register
// offsets (word index iomem_addr[3:2]), CTRL bit positions and reset values.
// -----------------------------------------------------------------------------
package seg_display_pkg;

  // Register word indices
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BRIGHT = 2'd3;

  // CTRL layout: [3:0] blank mask, [4] colon, [5] enable
  localparam int unsigned CTRL_COLON_BIT  = 4;
  localparam int unsigned CTRL_ENABLE_BIT = 5;

  localparam logic [5:0] CTRL_RESET   = 6'b100000;
  localparam logic [3:0] BRIGHT_RESET = 4'hF;
  localparam logic [3:0] COMM_OFF     = 4'hF;

endpackage

// File: rtl/seg_display_periph_hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Purely combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble in  4 : hex digit value
//   seg    out 7 : active-high segments, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Standard gfedcba segment codes
  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_display_periph.sv
// -----------------------------------------------------------------------------
// seg_display_periph
// Memory-mapped 4-digit seven-segment display controller on the PicoSoC
// iomem bus. Time-multiplexes DATA[15:0] onto the digit selects.
// Optional feature macro: SEG_DISPLAY_DIM_EN (PWM brightness via BRIGHT).
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   iomem_valid/ready      : request / one-cycle acknowledge
//   iomem_wstrb/addr/wdata : byte strobes (0 = read), address, write data
//   iomem_rdata            : read data, 0 whenever iomem_ready is 0
//   comm                   : active-low one-hot digit select
//   seg                    : active-high segments (g..a)
//   colon                  : colon LED, active high
// -----------------------------------------------------------------------------
module seg_display_periph
  import seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 3840,
  parameter logic [7:0]  ADDR_HI     = 8'h04
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [3:0]  comm,
  output logic [6:0]  seg,
  output logic        colon
);

  localparam logic [23:0] SCAN_RELOAD = 24'(REFRESH_DIV - 1);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] data_q, data_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        frame_q, frame_d;
  logic [3:0]  comm_q, comm_d;
  logic [6:0]  seg_q, seg_d;
  logic        colon_q, colon_d;

  logic        sel_s, rd_req_s, wr_req_s;
  logic [1:0]  reg_sel_s;
  logic [31:0] rd_val_s;
  logic [3:0]  bright_rd_s;
  logic        duty_on_s;
  logic [3:0]  nibble_s;
  logic [6:0]  seg_dec_s;
  logic [3:0]  blank_mask_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16]};

  // Bus decode; the !ready_q term forces an idle cycle between accesses
  always_comb begin
    sel_s     = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
    rd_req_s  = sel_s && (iomem_wstrb == 4'b0000);
    wr_req_s  = sel_s && (iomem_wstrb != 4'b0000);
    reg_sel_s = iomem_addr[3:2];
  end

`ifdef SEG_DISPLAY_DIM_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] pwm_q, pwm_d;

  // BRIGHT register and free-running PWM phase; digit lit while pwm <= BRIGHT
  always_comb begin
    bright_d  = (wr_req_s && (reg_sel_s == REG_BRIGHT) && iomem_wstrb[0])
                ? iomem_wdata[3:0] : bright_q;
    pwm_d     = pwm_q + 4'd1;
    duty_on_s = (pwm_q <= bright_q);
  end

  // Brightness state flops
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bright_q <= BRIGHT_RESET;
      pwm_q    <= 4'd0;
    end else begin
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
    end
  end

  assign bright_rd_s = bright_q;
`else
  assign bright_rd_s = 4'h0;
  assign duty_on_s   = 1'b1;
`endif

  // Read data mux
  always_comb begin
    rd_val_s = 32'h0;
    case (reg_sel_s)
      REG_DATA:   rd_val_s = {16'h0, data_q};
      REG_CTRL:   rd_val_s = {26'h0, ctrl_q};
      REG_STATUS: rd_val_s = {29'h0, frame_q, idx_q};
      REG_BRIGHT: rd_val_s = {28'h0, bright_rd_s};
      default:    rd_val_s = 32'h0;
    endcase
  end

  // Bus response, register writes, scan counter and frame flag
  always_comb begin
    ready_d = sel_s;
    rdata_d = rd_req_s ? rd_val_s : 32'h0;

    data_d[7:0]  = (wr_req_s && (reg_sel_s == REG_DATA) && iomem_wstrb[0])
                   ? iomem_wdata[7:0] : data_q[7:0];
    data_d[15:8] = (wr_req_s && (reg_sel_s == REG_DATA) && iomem_wstrb[1])
                   ? iomem_wdata[15:8] : data_q[15:8];
    ctrl_d       = (wr_req_s && (reg_sel_s == REG_CTRL) && iomem_wstrb[0])
                   ? iomem_wdata[5:0] : ctrl_q;

    if (cnt_q == 24'd0) begin
      cnt_d = SCAN_RELOAD;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q - 24'd1;
      idx_d = idx_q;
    end

    // A wrap on the same cycle as a STATUS read keeps the flag set
    if ((cnt_q == 24'd0) && (idx_q == 2'd3)) begin
      frame_d = 1'b1;
    end else if (rd_req_s && (reg_sel_s == REG_STATUS)) begin
      frame_d = 1'b0;
    end else begin
      frame_d = frame_q;
    end
  end

  // Nibble for the digit being shown next cycle, so outputs track idx_q
  always_comb begin
    nibble_s = 4'h0;
    case (idx_d)
      2'd0:    nibble_s = data_q[3:0];
      2'd1:    nibble_s = data_q[7:4];
      2'd2:    nibble_s = data_q[11:8];
      2'd3:    nibble_s = data_q[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  hex7seg u_hex7seg (
    .nibble (nibble_s),
    .seg    (seg_dec_s)
  );

  // Display output next-state; a blanked digit keeps decoding seg
  always_comb begin
    blank_mask_s = ctrl_q[3:0];
    if (!ctrl_q[CTRL_ENABLE_BIT]) begin
      comm_d  = COMM_OFF;
      seg_d   = 7'h00;
      colon_d = 1'b0;
    end else begin
      seg_d   = seg_dec_s;
      colon_d = ctrl_q[CTRL_COLON_BIT];
      if (blank_mask_s[idx_d] || !duty_on_s) begin
        comm_d = COMM_OFF;
      end else begin
        comm_d = ~(4'b0001 << idx_d);
      end
    end
  end

  // State flops with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      data_q  <= 16'h0;
      ctrl_q  <= CTRL_RESET;
      cnt_q   <= SCAN_RELOAD;
      idx_q   <= 2'd0;
      frame_q <= 1'b0;
      comm_q  <= 4'b1110;
      seg_q   <= 7'h3F;
      colon_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      comm_q  <= comm_d;
      seg_q   <= seg_d;
      colon_q <= colon_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign comm        = comm_q;
  assign seg         = seg_q;
  assign colon       = colon_q;

endmodule

// File: tb/tb_seg_display_periph.sv
// -----------------------------------------------------------------------------
// tb_seg_display_periph
// Directed self-checking bench for seg_display_periph with REFRESH_DIV = 4.
// edge_cnt counts clock edges since the last reset edge; digit index k is
// shown between edges 4k..4k+3 of every 16-edge frame.
// -----------------------------------------------------------------------------
module tb_seg_display_periph;

  localparam logic [31:0] A_DATA   = 32'h0400_0000;
  localparam logic [31:0] A_CTRL   = 32'h0400_0004;
  localparam logic [31:0] A_STATUS = 32'h0400_0008;
  localparam logic [31:0] A_BRIGHT = 32'h0400_000C;
`ifdef SEG_DISPLAY_DIM_EN
  localparam logic [31:0] BRIGHT_DEF = 32'hF;
  localparam logic [31:0] BRIGHT_3   = 32'h3;
  localparam logic [31:0] LIT_CYCLES = 32'd4;
`else
  localparam logic [31:0] BRIGHT_DEF = 32'h0;
  localparam logic [31:0] BRIGHT_3   = 32'h0;
  localparam logic [31:0] LIT_CYCLES = 32'd16;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [3:0]  comm;
  logic [6:0]  seg;
  logic        colon;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int edge_cnt  = 0;

  logic [31:0] rd;
  logic [31:0] lit;

  seg_display_periph #(.REFRESH_DIV(4), .ADDR_HI(8'h04)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .comm        (comm),
    .seg         (seg),
    .colon       (colon)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!resetn) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    @(negedge clk);
    check("wr_ack", {31'h0, iomem_ready}, 32'h1);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge clk);
    check("wr_ack_one_cycle", {31'h0, iomem_ready}, 32'h0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = 4'h0;
    @(negedge clk);
    check("rd_ack", {31'h0, iomem_ready}, 32'h1);
    d = iomem_rdata;
    iomem_valid = 1'b0;
    @(negedge clk);
    check("rd_ack_one_cycle", {31'h0, iomem_ready}, 32'h0);
    check("rdata_idle_zero", iomem_rdata, 32'h0);
  endtask

  // Advance to the negedge following edge (16k + ph)
  task automatic wait_phase(input int ph);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((edge_cnt % 16) == ph) begin
        found = 1'b1;
        break;
      end
    end
    check("phase_sync", {31'h0, found}, 32'h1);
  endtask

  // Sample one full frame starting at slot 0; ec/es packed {slot3..slot0}
  task automatic scan_check(input string tag, input logic [15:0] ec,
                            input logic [27:0] es, input logic ecol);
    for (int j = 0; j < 16; j++) begin
      int s;
      s = j / 4;
      check({tag, "_comm"},  {28'h0, comm},  {28'h0, ec[4*s +: 4]});
      check({tag, "_seg"},   {25'h0, seg},   {25'h0, es[7*s +: 7]});
      check({tag, "_colon"}, {31'h0, colon}, {31'h0, ecol});
      if (j < 15) @(negedge clk);
    end
  endtask

  initial begin
    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    iomem_addr = 32'h0; iomem_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_comm",  {28'h0, comm},  32'hE);
    check("rst_seg",   {25'h0, seg},   32'h3F);
    check("rst_colon", {31'h0, colon}, 32'h0);
    check("rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;

    bus_read(A_CTRL, rd);   check("rst_ctrl",   rd, 32'h20);
    bus_read(A_DATA, rd);   check("rst_data",   rd, 32'h0);
    bus_read(A_BRIGHT, rd); check("rst_bright", rd, BRIGHT_DEF);

    // Digits 0..3 = F, A, 2, 1
    bus_write(A_DATA, 32'h0000_12AF, 4'hF);
    wait_phase(0);
    scan_check("scan_data", 16'h7BDE, {7'h06, 7'h5B, 7'h77, 7'h71}, 1'b0);

    // Blank digits 0 and 2; seg still decodes there
    bus_write(A_CTRL, 32'h25, 4'hF);
    wait_phase(0);
    scan_check("scan_blank", 16'h7FDF, {7'h06, 7'h5B, 7'h77, 7'h71}, 1'b0);

    bus_write(A_CTRL, 32'h30, 4'hF);
    wait_phase(0);
    scan_check("scan_colon", 16'h7BDE, {7'h06, 7'h5B, 7'h77, 7'h71}, 1'b1);

    // Disabled: colon bit set but forced off
    bus_write(A_CTRL, 32'h10, 4'hF);
    wait_phase(0);
    scan_check("scan_off", 16'hFFFF, 28'h0, 1'b0);

    // Byte-lane write to DATA low byte only
    bus_write(A_DATA, 32'hFFFF_FF34, 4'b0001);
    bus_read(A_DATA, rd); check("byte_write", rd, 32'h1234);

    // Unselected slot: no acknowledge, no state change
    iomem_valid = 1'b1; iomem_addr = 32'h0500_0000;
    iomem_wdata = 32'h0000_FFFF; iomem_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("unsel_no_ack", {31'h0, iomem_ready}, 32'h0);
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge clk);
    bus_read(A_DATA, rd); check("unsel_data", rd, 32'h1234);

    // STATUS is read-only but still acknowledged
    bus_write(A_STATUS, 32'hFFFF_FFFF, 4'hF);

    // frame flag: set on wrap, cleared by read, set wins on coincidence
    wait_phase(0);
    bus_read(A_STATUS, rd); check("frame_set",     rd, 32'h4);
    bus_read(A_STATUS, rd); check("frame_cleared", rd, 32'h0);
    wait_phase(15);
    bus_read(A_STATUS, rd); check("frame_coinc_rd", rd, 32'h3);
    bus_read(A_STATUS, rd); check("frame_set_wins", rd, 32'h4);
    bus_read(A_STATUS, rd); check("frame_clr_again", rd, 32'h0);

    // Brightness
    bus_write(A_CTRL, 32'h20, 4'hF);
    bus_write(A_BRIGHT, 32'h3, 4'hF);
    bus_read(A_BRIGHT, rd); check("bright_rd", rd, BRIGHT_3);
    @(negedge clk);
    lit = 32'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (comm != 4'hF) lit = lit + 32'd1;
    end
    check("bright_duty", lit, LIT_CYCLES);

    // Reset mid-scan at digit 2 with a pending write
    bus_write(A_DATA, 32'h0000_5678, 4'hF);
    wait_phase(8);
    iomem_valid = 1'b1; iomem_addr = A_DATA; iomem_wdata = 32'h0000_BEEF;
    iomem_wstrb = 4'hF; resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("mid_rst_rdata", iomem_rdata, 32'h0);
    check("mid_rst_comm",  {28'h0, comm},  32'hE);
    check("mid_rst_seg",   {25'h0, seg},   32'h3F);
    check("mid_rst_colon", {31'h0, colon}, 32'h0);
    resetn = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    bus_read(A_STATUS, rd); check("mid_rst_status", rd, 32'h0);
    bus_read(A_DATA, rd);   check("mid_rst_data",   rd, 32'h0);
    bus_read(A_CTRL, rd);   check("mid_rst_ctrl",   rd, 32'h20);
    bus_read(A_BRIGHT, rd); check("mid_rst_bright", rd, BRIGHT_DEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
